// File: rtl/apb_mem_arbiter.sv
// 2:1 APB arbiter: instruction-fetch master (m0) and data master (m1) share one
// APB memory slave. Transfers are serialized through a registered IDLE/SETUP/ACCESS
// FSM. Ties are broken round-robin, or in favour of m1 when FIXED_PRIO is set.
// A watchdog aborts transfers whose slave never raises pready.
module apb_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                clk,
    input  logic                rst,
    // master 0 (instruction fetch)
    input  logic                m0_psel,
    input  logic                m0_penable,
    input  logic                m0_pwrite,
    input  logic [ADDR_W-1:0]   m0_paddr,
    input  logic [DATA_W-1:0]   m0_pwdata,
    input  logic [DATA_W/8-1:0] m0_pstrb,
    output logic [DATA_W-1:0]   m0_prdata,
    output logic                m0_pready,
    output logic                m0_pslverr,
    // master 1 (data)
    input  logic                m1_psel,
    input  logic                m1_penable,
    input  logic                m1_pwrite,
    input  logic [ADDR_W-1:0]   m1_paddr,
    input  logic [DATA_W-1:0]   m1_pwdata,
    input  logic [DATA_W/8-1:0] m1_pstrb,
    output logic [DATA_W-1:0]   m1_prdata,
    output logic                m1_pready,
    output logic                m1_pslverr,
    // downstream slave
    output logic                s_psel,
    output logic                s_penable,
    output logic                s_pwrite,
    output logic [ADDR_W-1:0]   s_paddr,
    output logic [DATA_W-1:0]   s_pwdata,
    output logic [DATA_W/8-1:0] s_pstrb,
    input  logic [DATA_W-1:0]   s_prdata,
    input  logic                s_pready,
    input  logic                s_pslverr
);

    // A zero timeout disables the watchdog; keep the counter at least 1 bit wide.
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state;
    logic            grant;       // 0: m0 owns the current transfer, 1: m1
    logic            last_grant;  // owner of the most recently finished transfer
    logic [WD_W-1:0] wd_cnt;
    logic            pick;
    logic            timeout;
    logic            done;

    // The request is psel alone; penable carries nothing the arbiter needs.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // Grant choice for a new transfer: on a tie either m1 (fixed) or the master
    // that did not go last (round-robin).
    always_comb begin
        pick = m1_psel;
        if (m0_psel && m1_psel)
            pick = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant;
    end

    assign timeout = (TIMEOUT_CYC != 0) && (state == ACCESS) && !s_pready &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC));
    assign done    = (state == ACCESS) && (s_pready || timeout);

    // Transfer sequencer: latches the winner's payload and drives the slave bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
            s_psel     <= 1'b0;
            s_penable  <= 1'b0;
            s_pwrite   <= 1'b0;
            s_paddr    <= '0;
            s_pwdata   <= '0;
            s_pstrb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_psel || m1_psel) begin
                        grant     <= pick;
                        s_pwrite  <= pick ? m1_pwrite : m0_pwrite;
                        s_paddr   <= pick ? m1_paddr  : m0_paddr;
                        s_pwdata  <= pick ? m1_pwdata : m0_pwdata;
                        s_pstrb   <= pick ? m1_pstrb  : m0_pstrb;
                        s_psel    <= 1'b1;
                        s_penable <= 1'b0;
                        wd_cnt    <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    s_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        last_grant <= grant;
                        s_psel     <= 1'b0;
                        s_penable  <= 1'b0;
                        state      <= IDLE;
                    end else if (!s_pready && (wd_cnt < WD_W'(TIMEOUT_CYC))) begin
                        // saturates at the timeout value, never wraps
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion response is routed only to the owner; an abort forces an error
    // with zero data. Everything else sees a stalled, quiet bus.
    always_comb begin
        m0_pready  = 1'b0;
        m0_pslverr = 1'b0;
        m0_prdata  = '0;
        m1_pready  = 1'b0;
        m1_pslverr = 1'b0;
        m1_prdata  = '0;
        if (done) begin
            if (grant) begin
                m1_pready  = 1'b1;
                m1_pslverr = s_pready ? s_pslverr : 1'b1;
                m1_prdata  = s_pready ? s_prdata : '0;
            end else begin
                m0_pready  = 1'b1;
                m0_pslverr = s_pready ? s_pslverr : 1'b1;
                m0_prdata  = s_pready ? s_prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Directed bench for apb_mem_arbiter: a round-robin instance with a programmable
// wait-state slave, plus a fixed-priority instance with a zero-wait slave.
module tb_apb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic [31:0] m0_paddr, m0_pwdata;
    logic [3:0]  m0_pstrb;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m1_paddr, m1_pwdata;
    logic [3:0]  m1_pstrb;

    // round-robin instance
    logic [31:0] m0_prdata, m1_prdata, s_paddr, s_pwdata, s_prdata;
    logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
    logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [3:0]  s_pstrb;

    // fixed-priority instance
    logic [31:0] fp_m0_prdata, fp_m1_prdata, fp_s_paddr, fp_s_pwdata;
    logic        fp_m0_pready, fp_m0_pslverr, fp_m1_pready, fp_m1_pslverr;
    logic        fp_s_psel, fp_s_penable, fp_s_pwrite, fp_s_pready;
    logic [3:0]  fp_s_pstrb;

    // slave model for the round-robin instance
    int          acc_cnt = 0;
    int          slave_waits = 0;
    bit          slave_hang = 1'b0;
    logic [31:0] slave_rdata = '0;

    int checks = 0;
    int errors = 0;
    int who, cyc, n;

    always #5 clk = ~clk;

    assign s_pready  = s_psel && s_penable && !slave_hang && (acc_cnt >= slave_waits);
    assign s_prdata  = slave_rdata;
    assign s_pslverr = 1'b0;
    always @(posedge clk)
        acc_cnt <= (s_psel && s_penable && !s_pready) ? acc_cnt + 1 : 0;

    assign fp_s_pready = fp_s_psel && fp_s_penable;

    apb_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
        .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
        .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr)
    );

    apb_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYC(16)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
        .m0_prdata(fp_m0_prdata), .m0_pready(fp_m0_pready), .m0_pslverr(fp_m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
        .m1_prdata(fp_m1_prdata), .m1_pready(fp_m1_pready), .m1_pslverr(fp_m1_pslverr),
        .s_psel(fp_s_psel), .s_penable(fp_s_penable), .s_pwrite(fp_s_pwrite),
        .s_paddr(fp_s_paddr), .s_pwdata(fp_s_pwdata), .s_pstrb(fp_s_pstrb),
        .s_prdata(32'h0), .s_pready(fp_s_pready), .s_pslverr(1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // wait (bounded) for a completion on the round-robin instance
    task automatic wait_done(output int w, output int c);
        w = -1;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (m0_pready || m1_pready) begin
                w = m1_pready ? 1 : 0;
                c = i;
                break;
            end
            if (m0_psel) m0_penable = 1'b1;
            if (m1_psel) m1_penable = 1'b1;
        end
    endtask

    // wait (bounded) for a completion on the fixed-priority instance
    task automatic wait_fp(output int w);
        w = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (fp_m0_pready || fp_m1_pready) begin
                w = fp_m1_pready ? 1 : 0;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        {m0_psel, m0_penable, m0_pwrite, m1_psel, m1_penable, m1_pwrite} = '0;
        m0_paddr = '0; m0_pwdata = '0; m0_pstrb = '0;
        m1_paddr = '0; m1_pwdata = '0; m1_pstrb = '0;
        @(negedge clk);
        step();
        step();
        // reset state
        chk("rst_psel",    s_psel,    1'b0);
        chk("rst_penable", s_penable, 1'b0);
        chk("rst_pwrite",  s_pwrite,  1'b0);
        chk("rst_paddr",   s_paddr,   32'h0);
        chk("rst_pwdata",  s_pwdata,  32'h0);
        chk("rst_pstrb",   s_pstrb,   4'h0);
        chk("rst_m0_rdy",  m0_pready, 1'b0);
        chk("rst_m1_rdy",  m1_pready, 1'b0);
        rst = 1'b0;

        // 1: zero-wait read by m0
        slave_rdata = 32'hAAAAAAAA;
        m0_psel = 1'b1; m0_paddr = 32'h18; m0_pwrite = 1'b0;
        step();
        chk("t1_setup_psel", s_psel,    1'b1);
        chk("t1_setup_pen",  s_penable, 1'b0);
        chk("t1_paddr",      s_paddr,   32'h18);
        chk("t1_setup_rdy",  m0_pready, 1'b0);
        m0_penable = 1'b1;
        step();
        chk("t1_acc_pen",    s_penable,  1'b1);
        chk("t1_rdy",        m0_pready,  1'b1);
        chk("t1_rdata",      m0_prdata,  32'hAAAAAAAA);
        chk("t1_slverr",     m0_pslverr, 1'b0);
        chk("t1_m1_rdy",     m1_pready,  1'b0);
        m0_psel = 1'b0; m0_penable = 1'b0;
        step();
        chk("t1_idle_psel",  s_psel, 1'b0);

        // 2: round-robin alternation after reset
        do_reset();
        m0_psel = 1'b1; m0_paddr = 32'h100;
        m1_psel = 1'b1; m1_paddr = 32'h200;
        wait_done(who, cyc);
        chk("t2_first_m0",   who,       0);
        chk("t2_first_lat",  cyc,       2);
        chk("t2_first_addr", s_paddr,   32'h100);
        chk("t2_m1_stall",   m1_pready, 1'b0);
        chk("t2_m1_rdata",   m1_prdata, 32'h0);
        m0_paddr = 32'h104; m0_penable = 1'b0;  // m0 re-requests back to back
        wait_done(who, cyc);
        chk("t2_second_m1",  who,     1);
        chk("t2_second_lat", cyc,     3);
        chk("t2_second_addr", s_paddr, 32'h200);
        m1_psel = 1'b0; m1_penable = 1'b0; m0_penable = 1'b0;
        wait_done(who, cyc);
        chk("t2_third_m0",   who,     0);
        chk("t2_third_addr", s_paddr, 32'h104);
        m0_psel = 1'b0; m0_penable = 1'b0;
        step();

        // 3: fixed priority, 4 ties all go to m1, then m0 once m1 backs off
        do_reset();
        m0_psel = 1'b1; m0_paddr = 32'h300;
        m1_psel = 1'b1; m1_paddr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            wait_fp(who);
            chk("t3_tie_m1", who, 1);
            chk("t3_m0_stall", fp_m0_pready, 1'b0);
        end
        m1_psel = 1'b0;
        wait_fp(who);
        chk("t3_m0_served", who, 0);
        m0_psel = 1'b0;
        step();

        // 4: m1 write with 3 slave wait states; payload must stay frozen
        do_reset();
        slave_waits = 3;
        m1_psel = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h8;
        m1_pwdata = 32'h00010368; m1_pstrb = 4'b0011;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t4_paddr",  s_paddr,   32'h8);
            chk("t4_pwdata", s_pwdata,  32'h00010368);
            chk("t4_pstrb",  s_pstrb,   4'b0011);
            chk("t4_pwrite", s_pwrite,  1'b1);
            chk("t4_m0_rdy", m0_pready, 1'b0);
            chk("t4_m1_rdy", m1_pready, (k == 5) ? 1'b1 : 1'b0);
            if (k == 1) begin
                m1_penable = 1'b1;
                m1_paddr = 32'hFC; m1_pwdata = 32'hDEADBEEF; m1_pstrb = 4'hF;
            end
        end
        m1_psel = 1'b0; m1_penable = 1'b0; m1_pwrite = 1'b0;
        slave_waits = 0;
        step();

        // 5: hung slave, watchdog abort after 16 stalled ACCESS cycles
        do_reset();
        slave_hang = 1'b1; slave_rdata = 32'h12345678;
        m0_psel = 1'b1; m0_paddr = 32'h40;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m0_pready) break;
            if (s_penable) n++;
        end
        chk("t5_acc_cycles", n,          16);
        chk("t5_rdy",        m0_pready,  1'b1);
        chk("t5_slverr",     m0_pslverr, 1'b1);
        chk("t5_rdata",      m0_prdata,  32'h0);
        m0_psel = 1'b0;
        step();
        chk("t5_idle_psel",  s_psel,    1'b0);
        chk("t5_idle_pen",   s_penable, 1'b0);

        // 6: reset mid-ACCESS, then a clean transfer
        m0_psel = 1'b1; m0_paddr = 32'h44;
        step();
        step();
        chk("t6_in_access",  s_penable, 1'b1);
        rst = 1'b1;
        step();
        chk("t6_rst_psel",   s_psel,    1'b0);
        chk("t6_rst_pen",    s_penable, 1'b0);
        chk("t6_rst_m0_rdy", m0_pready, 1'b0);
        chk("t6_rst_m1_rdy", m1_pready, 1'b0);
        m0_psel = 1'b0; rst = 1'b0; slave_hang = 1'b0;
        step();
        slave_rdata = 32'h5A5A5A5A;
        m1_psel = 1'b1; m1_paddr = 32'h20;
        wait_done(who, cyc);
        chk("t6_after_who",   who,        1);
        chk("t6_after_lat",   cyc,        2);
        chk("t6_after_rdata", m1_prdata,  32'h5A5A5A5A);
        chk("t6_after_err",   m1_pslverr, 1'b0);
        m1_psel = 1'b0; m1_penable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
